fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch.sv | 44 ++++
 tb/tb_fetch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared CPU pipeline widths, PC step and fetch state encoding
package fetch_pkg;
  localparam int PC_WIDTH        = 12;
  localparam int PMEM_ADDR_WIDTH = 12;
  localparam int PMEM_WORD_WIDTH = 16;
  localparam int PC_INCREMENT    = 2;
  typedef enum logic {BOOT, RUN} fetch_state_e;
endpackage

// File: rtl/fetch.sv
// fetch: instruction fetch stage driving a synchronous program memory
module fetch #(
  parameter int PC_WIDTH        = fetch_pkg::PC_WIDTH,
  parameter int PMEM_ADDR_WIDTH = fetch_pkg::PMEM_ADDR_WIDTH,
  parameter int PMEM_WORD_WIDTH = fetch_pkg::PMEM_WORD_WIDTH,
  parameter int PC_INCREMENT    = fetch_pkg::PC_INCREMENT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_set_pc,
  input  logic [PMEM_ADDR_WIDTH-1:0] in_branch_pc,
  input  logic                       in_flush,
  input  logic                       in_stall,
  input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_rd_word,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_rd_addr,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_flush
);
  import fetch_pkg::*;
  fetch_state_e state_q, state_d;
  logic [PMEM_ADDR_WIDTH-1:0] pc_ff_q, pc_ff_d;
  logic boot;
  // Next-address mux (redirect beats stall beats increment) and bubble masking
  always_comb begin
    boot = state_q == BOOT;
    state_d = RUN;
    pc_ff_d = boot ? '0 : in_set_pc ? in_branch_pc : in_stall ? pc_ff_q : pc_ff_q + PMEM_ADDR_WIDTH'(PC_INCREMENT);
    out_pmem_rd_addr = pc_ff_d;
    out_flush = boot | in_flush | in_set_pc;
    out_instr = out_flush ? '0 : in_pmem_rd_word;
    out_pc = out_flush ? '0 : PC_WIDTH'(pc_ff_q);
  end
  // pc_ff tracks the address whose word arrives from memory next cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_ff_q <= '0;
    end else begin
      state_q <= state_d;
      pc_ff_q <= pc_ff_d;
    end
  end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: randomized self-checking bench for fetch against a cycle-level reference model
module tb_fetch;
  logic clock = 0;
  logic reset = 1;
  logic in_set_pc = 0, in_flush = 0, in_stall = 0;
  logic [11:0] in_branch_pc = 0;
  logic [15:0] in_pmem_rd_word;
  logic [11:0] out_pmem_rd_addr;
  logic [15:0] out_instr;
  logic [11:0] out_pc;
  logic out_flush;
  logic [15:0] mem [4096];
  int passed = 0, total = 0;
  logic m_run = 0;
  logic [11:0] m_pc = 0;
  logic [40:0] got, exp;

  fetch dut (
    .clock(clock), .reset(reset), .in_set_pc(in_set_pc), .in_branch_pc(in_branch_pc),
    .in_flush(in_flush), .in_stall(in_stall), .in_pmem_rd_word(in_pmem_rd_word),
    .out_pmem_rd_addr(out_pmem_rd_addr), .out_instr(out_instr), .out_pc(out_pc), .out_flush(out_flush)
  );

  always #5 clock = ~clock;
  always @(posedge clock) in_pmem_rd_word <= mem[out_pmem_rd_addr];

  // Expected {addr, instr, pc, flush} for this cycle from the fetch rules
  function automatic logic [40:0] model(input logic s, input logic [11:0] b, input logic f, input logic st);
    logic [11:0] a;
    logic fl;
    if (!m_run) a = 0;
    else if (s) a = b;
    else if (st) a = m_pc;
    else a = 12'((int'(m_pc) + 2) % 4096);
    fl = !m_run || f || s;
    return {a, fl ? 16'd0 : mem[m_pc], fl ? 12'd0 : m_pc, fl};
  endfunction

  task automatic drive(input logic s, input logic [11:0] b, input logic f, input logic st);
    @(negedge clock);
    in_set_pc = s; in_branch_pc = b; in_flush = f; in_stall = st;
    #1;
    exp = model(s, b, f, st);
    got = {out_pmem_rd_addr, out_instr, out_pc, out_flush};
  endtask

  task automatic tick();
    @(posedge clock);
    m_run = 1;
    m_pc = exp[40:29];
  endtask

  task automatic test_reset();
    #1;
    got = {out_pmem_rd_addr, out_instr, out_pc, out_flush};
    total++; if (got !== 41'd1) $display("FAIL reset_hold got=%h exp=%h", got, 41'd1); else passed++;
    @(negedge clock);
    reset = 0;
    #1;
    exp = model(0, 0, 0, 0);
    got = {out_pmem_rd_addr, out_instr, out_pc, out_flush};
    total++; if (got !== 41'd1) $display("FAIL boot_bubble got=%h exp=%h", got, 41'd1); else passed++;
    tick();
    drive(0, 0, 0, 0);
    total++; if (got !== exp || out_instr !== 16'h1234 || out_pc !== 12'h000) $display("FAIL first_word got=%h exp=%h", got, exp); else passed++;
    tick();
    drive(0, 0, 0, 0);
    total++; if (got !== exp || out_instr !== 16'hABCD || out_pc !== 12'h002) $display("FAIL second_word got=%h exp=%h", got, exp); else passed++;
    tick();
  endtask

  task automatic test_redirect();
    drive(1, 12'h010, 0, 0); tick();
    drive(1, 12'h040, 0, 0);
    total++; if (got !== exp || out_flush !== 1 || out_pmem_rd_addr !== 12'h040) $display("FAIL redirect_issue got=%h exp=%h", got, exp); else passed++;
    tick();
    drive(0, 0, 0, 0);
    total++; if (got !== exp || out_instr !== mem[12'h040] || out_pc !== 12'h040 || out_flush !== 0) $display("FAIL redirect_land got=%h exp=%h", got, exp); else passed++;
    tick();
  endtask

  task automatic test_stall();
    drive(1, 12'h020, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      total++; if (got !== exp || out_pmem_rd_addr !== 12'h020 || out_instr !== mem[12'h020] || out_pc !== 12'h020) $display("FAIL stall_hold%0d got=%h exp=%h", i, got, exp); else passed++;
      tick();
    end
    drive(0, 0, 0, 0);
    total++; if (got !== exp || out_pmem_rd_addr !== 12'h022) $display("FAIL stall_release got=%h exp=%h", got, exp); else passed++;
    tick();
    drive(0, 0, 1, 1);
    total++; if (got !== exp || out_pmem_rd_addr !== 12'h022 || out_flush !== 1) $display("FAIL stall_flush got=%h exp=%h", got, exp); else passed++;
    tick();
  endtask

  task automatic test_wrap();
    drive(1, 12'hFFE, 0, 0); tick();
    drive(0, 0, 0, 0);
    total++; if (got !== exp || out_pmem_rd_addr !== 12'h000 || out_pc !== 12'hFFE) $display("FAIL wrap_addr got=%h exp=%h", got, exp); else passed++;
    tick();
    drive(0, 0, 0, 0);
    total++; if (got !== exp || out_pc !== 12'h000 || out_flush !== 0) $display("FAIL wrap_pc got=%h exp=%h", got, exp); else passed++;
    tick();
  endtask

  task automatic test_combo();
    drive(1, 12'h100, 1, 1);
    total++; if (got !== exp || out_pmem_rd_addr !== 12'h100 || out_flush !== 1) $display("FAIL combo_issue got=%h exp=%h", got, exp); else passed++;
    tick();
    drive(0, 0, 0, 0);
    total++; if (got !== exp || out_pc !== 12'h100) $display("FAIL combo_land got=%h exp=%h", got, exp); else passed++;
    tick();
    drive(1, 12'h033, 0, 0); tick();
    drive(0, 0, 0, 0);
    total++; if (got !== exp || out_pc !== 12'h033 || out_pmem_rd_addr !== 12'h035) $display("FAIL odd_target got=%h exp=%h", got, exp); else passed++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 4) == 0, 12'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      total++; if (got !== exp) $display("FAIL random%0d got=%h exp=%h", i, got, exp); else passed++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 12'h0A0, 0, 0); tick();
    @(negedge clock);
    in_set_pc = 1; in_branch_pc = 12'h3C0; in_stall = 1;
    #2 reset = 1;
    #1;
    m_run = 0; m_pc = 0;
    got = {out_pmem_rd_addr, out_instr, out_pc, out_flush};
    total++; if (got !== 41'd1) $display("FAIL reset_mid got=%h exp=%h", got, 41'd1); else passed++;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0; in_set_pc = 0; in_stall = 0;
    #1;
    exp = model(0, 0, 0, 0);
    got = {out_pmem_rd_addr, out_instr, out_pc, out_flush};
    total++; if (got !== 41'd1) $display("FAIL reset_reboot got=%h exp=%h", got, 41'd1); else passed++;
    tick();
    drive(0, 0, 0, 0);
    total++; if (got !== exp || out_pc !== 12'h000 || out_instr !== 16'h1234) $display("FAIL reset_restart got=%h exp=%h", got, exp); else passed++;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;
    mem[2] = 16'hABCD;
    test_reset();
    test_redirect();
    test_stall();
    test_wrap();
    test_combo();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
